spi_target_ctrl: RTL and testbench

SPI_TARGET_CTRL -- requirements
Module: spi_target_ctrl

---
 rtl/spi_target_pkg.sv | 20 ++
 rtl/spi_edge_sync.sv | 61 ++++++
 rtl/spi_target_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spi_target_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target controller.
package spi_target_pkg;

  localparam int CTRL_WIDTH = 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    CTRL,
    PAY_RX,
    PAY_TX
  } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the async SPI pins into clk and turns sclk transitions into
// single-cycle sample/shift strobes for the configured SPI mode.
module spi_edge_sync #(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sample_stb,
  output logic shift_stb,
  output logic ss_n_sync,
  output logic mosi_sync,
  output logic sync_live
);

  localparam logic IDLE_SCLK = 1'(CPOL);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] live_q;
  logic                   sclk_d;
  logic                   rise;
  logic                   fall;
  logic                   leading;
  logic                   trailing;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= {SYNC_STAGES{IDLE_SCLK}};
      ss_q   <= '1;
      mosi_q <= '0;
      live_q <= '0;
      sclk_d <= IDLE_SCLK;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      // live_q fills in lockstep with the chains: once set, ss_n_sync is a real pin sample
      live_q <= {live_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    rise       = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    fall       = ~sclk_q[SYNC_STAGES-1] & sclk_d;
    leading    = IDLE_SCLK ? fall : rise;
    trailing   = IDLE_SCLK ? rise : fall;
    sample_stb = (CPHA != 0) ? trailing : leading;
    shift_stb  = (CPHA != 0) ? leading : trailing;
    ss_n_sync  = ss_q[SYNC_STAGES-1];
    mosi_sync  = mosi_q[SYNC_STAGES-1];
    sync_live  = live_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/spi_target_ctrl.sv
// SPI target: 2-bit control prefix, then a write payload to the rx stream or
// a read payload served from tx_data, with overrun/underrun/framing status.
module spi_target_ctrl
  import spi_target_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sclk,
  input  logic                              ss_n,
  input  logic                              mosi,
  output logic                              miso,
  output logic                              miso_oe,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [FRAME_WIDTH+CTRL_WIDTH-1:0] rx_data,
  input  logic                              tx_valid,
  input  logic [FRAME_WIDTH-1:0]            tx_data,
  output logic                              tx_ack,
  output logic                              overrun,
  output logic                              underrun,
  output logic                              frame_err
);

  localparam int CW = $clog2(FRAME_WIDTH + 1);

  logic                   sample_stb;
  logic                   shift_stb;
  logic                   ss_n_sync;
  logic                   mosi_sync;
  logic                   sync_live;
  state_e                 state;
  logic [CW-1:0]          cnt;
  logic [CTRL_WIDTH-1:0]  ctrl;
  logic [CTRL_WIDTH-1:0]  ctrl_next;
  logic [FRAME_WIDTH-1:0] shreg;
  logic [FRAME_WIDTH-1:0] rx_word;
  logic                   last_bit;
  logic                   tx_started;
  logic                   armed;

  spi_edge_sync #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb),
    .ss_n_sync  (ss_n_sync),
    .mosi_sync  (mosi_sync),
    .sync_live  (sync_live)
  );

  always_comb begin
    ctrl_next = {ctrl[CTRL_WIDTH-2:0], mosi_sync};
    rx_word   = {shreg[FRAME_WIDTH-2:0], mosi_sync};
    last_bit  = (cnt == CW'(FRAME_WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl       <= '0;
      shreg      <= '0;
      tx_started <= 1'b0;
      armed      <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      tx_ack     <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      tx_ack    <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= ~ss_n_sync;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      // Arming needs a genuine high select so a select held low across reset is ignored
      if (ss_n_sync && sync_live) armed <= 1'b1;

      if (ss_n_sync && state != IDLE) begin
        if (cnt != '0) frame_err <= 1'b1;
        state      <= IDLE;
        cnt        <= '0;
        shreg      <= '0;
        miso       <= 1'b0;
        tx_started <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!ss_n_sync && armed) begin
              state <= CTRL;
              cnt   <= '0;
            end
          end
          CTRL: begin
            if (sample_stb) begin
              ctrl <= ctrl_next;
              if (cnt == CW'(CTRL_WIDTH - 1)) begin
                cnt        <= '0;
                tx_started <= 1'b0;
                state      <= (ctrl_next == RD_DATA) ? PAY_TX : PAY_RX;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          PAY_RX: begin
            if (sample_stb) begin
              shreg <= rx_word;
              if (last_bit) begin
                cnt   <= '0;
                shreg <= '0;
                state <= CTRL;
                if (!rx_valid || rx_ready) begin
                  rx_valid <= 1'b1;
                  rx_data  <= {ctrl, rx_word};
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          PAY_TX: begin
            // Bits are driven on shift edges but counted on sample edges, so the
            // last bit stays on miso until the host has actually sampled it.
            if (shift_stb) begin
              if (!tx_started) begin
                tx_started <= 1'b1;
                if (tx_valid) begin
                  shreg  <= tx_data;
                  miso   <= tx_data[FRAME_WIDTH-1];
                  tx_ack <= 1'b1;
                end else begin
                  shreg    <= '0;
                  miso     <= 1'b0;
                  underrun <= 1'b1;
                end
              end else begin
                miso  <= shreg[FRAME_WIDTH-2];
                shreg <= {shreg[FRAME_WIDTH-2:0], 1'b0};
              end
            end
            if (sample_stb) begin
              if (last_bit) begin
                cnt        <= '0;
                miso       <= 1'b0;
                tx_started <= 1'b0;
                state      <= CTRL;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target_ctrl.sv
// Directed bench: a mode-0 and a mode-3 instance exercised by bit-banged SPI
// transfers, with hand-computed expected frames and status pulse counts.
module tb_spi_target_ctrl;

  localparam int FW   = 8;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk0, ss_n0, sclk3, ss_n3, mosi;
  logic        rx_ready, tx_valid;
  logic [7:0]  tx_data;

  logic        miso0, miso_oe0, rx_valid0, tx_ack0, overrun0, underrun0, frame_err0;
  logic [9:0]  rx_data0;
  logic        miso3, miso_oe3, rx_valid3, tx_ack3, overrun3, underrun3, frame_err3;
  logic [9:0]  rx_data3;

  int compared   = 0;
  int mismatched = 0;

  int ovr0 = 0, fe0 = 0, rxr0 = 0;
  int ack3 = 0, und3 = 0, rxr3 = 0;
  logic rxv0_q = 1'b0, rxv3_q = 1'b0;
  int b_a, b_b, b_c;
  logic [7:0] rd;

  always #5 clk = ~clk;

  spi_target_ctrl #(.FRAME_WIDTH(FW), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss_n(ss_n0), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
    .rx_data(rx_data0), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ack(tx_ack0),
    .overrun(overrun0), .underrun(underrun0), .frame_err(frame_err0)
  );

  spi_target_ctrl #(.FRAME_WIDTH(FW), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_dut3 (
    .clk(clk), .rst(rst), .sclk(sclk3), .ss_n(ss_n3), .mosi(mosi),
    .miso(miso3), .miso_oe(miso_oe3), .rx_valid(rx_valid3), .rx_ready(rx_ready),
    .rx_data(rx_data3), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ack(tx_ack3),
    .overrun(overrun3), .underrun(underrun3), .frame_err(frame_err3)
  );

  always @(posedge clk) begin
    if (overrun0)  ovr0++;
    if (frame_err0) fe0++;
    if (rx_valid0 && !rxv0_q) rxr0++;
    rxv0_q = rx_valid0;
    if (tx_ack3)   ack3++;
    if (underrun3) und3++;
    if (rx_valid3 && !rxv3_q) rxr3++;
    rxv3_q = rx_valid3;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer0(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = bits[9-i];
      wait_clk(HALF);
      sclk0 = 1'b1;
      wait_clk(HALF);
      sclk0 = 1'b0;
    end
  endtask

  task automatic frame0(input logic [9:0] bits);
    ss_n0 = 1'b0;
    wait_clk(6);
    xfer0(bits, 10);
    wait_clk(6);
    ss_n0 = 1'b1;
    wait_clk(8);
  endtask

  task automatic xfer3(input logic [9:0] bits, output logic [7:0] got);
    got = '0;
    ss_n3 = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 10; i++) begin
      sclk3 = 1'b0;
      mosi  = bits[9-i];
      wait_clk(HALF);
      if (i >= 2) got = {got[6:0], miso3};
      sclk3 = 1'b1;
      wait_clk(HALF);
    end
    wait_clk(6);
    ss_n3 = 1'b1;
    wait_clk(8);
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sclk0 = 1'b0; ss_n0 = 1'b1; sclk3 = 1'b1; ss_n3 = 1'b1;
    mosi = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    wait_clk(3);
    check("reset_outputs_m0", {rx_valid0, rx_data0, miso0, miso_oe0, tx_ack0, overrun0, underrun0, frame_err0}, 0);
    check("reset_outputs_m3", {rx_valid3, rx_data3, miso3, miso_oe3, tx_ack3, overrun3, underrun3, frame_err3}, 0);
    rst = 1'b0;
    wait_clk(10);

    // Single mode-0 write frame, held until accepted
    b_a = rxr0;
    frame0(10'h1A5);
    check("m0_rx_valid", rx_valid0, 1);
    check("m0_rx_data", rx_data0, 10'h1A5);
    check("m0_rx_rise_once", rxr0 - b_a, 1);
    wait_clk(30);
    check("m0_rx_held", {rx_valid0, rx_data0}, {1'b1, 10'h1A5});
    accept();
    check("m0_rx_accepted", rx_valid0, 0);

    // Back-to-back frames with no consumer: second one overruns
    b_a = ovr0;
    ss_n0 = 1'b0;
    wait_clk(6);
    check("m0_miso_oe_low_ss", miso_oe0, 1);
    check("m0_miso_zero_ctrl", miso0, 0);
    xfer0(10'h1A5, 10);
    xfer0(10'h0FF, 10);
    wait_clk(6);
    ss_n0 = 1'b1;
    wait_clk(8);
    check("m0_overrun_once", ovr0 - b_a, 1);
    check("m0_overrun_data_kept", {rx_valid0, rx_data0}, {1'b1, 10'h1A5});
    check("m0_miso_oe_ss_high", miso_oe0, 0);
    accept();

    // Select rises mid-payload: framing error, then a clean frame
    b_a = fe0; b_b = rxr0;
    ss_n0 = 1'b0;
    wait_clk(6);
    xfer0(10'h1A5, 7);
    wait_clk(6);
    ss_n0 = 1'b1;
    wait_clk(8);
    check("m0_frame_err_once", fe0 - b_a, 1);
    check("m0_no_rx_on_abort", rxr0 - b_b, 0);
    frame0(10'h155);
    check("m0_after_abort_data", {rx_valid0, rx_data0}, {1'b1, 10'h155});
    accept();

    // Mode-3 write (RD_ADDR ctrl goes to the rx stream)
    b_a = rxr3;
    xfer3(10'h2A5, rd);
    check("m3_rx_data", {rx_valid3, rx_data3}, {1'b1, 10'h2A5});
    accept();

    // Mode-3 read data with payload available
    b_a = ack3; b_b = und3; b_c = rxr3;
    tx_valid = 1'b1; tx_data = 8'hC3;
    xfer3(10'h300, rd);
    check("m3_read_miso", rd, 8'hC3);
    check("m3_tx_ack_once", ack3 - b_a, 1);
    check("m3_read_no_underrun", und3 - b_b, 0);
    check("m3_read_no_rx", rxr3 - b_c, 0);
    check("m3_miso_idle", miso3, 0);

    // Mode-3 read data with nothing to send
    b_a = ack3; b_b = und3;
    tx_valid = 1'b0; tx_data = 8'hFF;
    xfer3(10'h300, rd);
    check("m3_underrun_miso", rd, 8'h00);
    check("m3_underrun_once", und3 - b_b, 1);
    check("m3_underrun_no_ack", ack3 - b_a, 0);

    // Reset mid-payload; select held low across reset must not start a frame
    b_a = fe0; b_b = ovr0; b_c = rxr0;
    ss_n0 = 1'b0;
    wait_clk(6);
    xfer0(10'h1A5, 6);
    rst = 1'b1;
    wait_clk(2);
    check("m0_midreset_outputs", {rx_valid0, rx_data0, miso0, miso_oe0, tx_ack0, overrun0, underrun0, frame_err0}, 0);
    rst = 1'b0;
    xfer0(10'h0FF, 4);
    wait_clk(6);
    ss_n0 = 1'b1;
    wait_clk(8);
    check("m0_midreset_no_status", {fe0 - b_a, ovr0 - b_b}, 0);
    check("m0_midreset_no_rx", rxr0 - b_c, 0);
    frame0(10'h0C3);
    check("m0_after_reset_data", {rx_valid0, rx_data0}, {1'b1, 10'h0C3});
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
